// File: rtl/execute_branch.sv
// execute_branch: ALU + branch/jump resolve, one-cycle latency, no backpressure (decode inserts NOPs).
// Optional BRANCH_STATS_EN adds saturating taken / not-taken / killed counters.
module execute_branch #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      shamt_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            prio_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic [XLEN-1:0] instr_o,
`ifdef BRANCH_STATS_EN
  output logic [XLEN-1:0] stat_taken_o,
  output logic [XLEN-1:0] stat_nottaken_o,
  output logic [XLEN-1:0] stat_killed_o,
`endif
  output logic            prio_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_BMU     = 7'b0110000;

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  function automatic logic [5:0] f_clz(input logic [XLEN-1:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < XLEN; i++) if (v[i]) n = 6'(XLEN - 1 - i);
    return n;
  endfunction

  function automatic logic [5:0] f_ctz(input logic [XLEN-1:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = XLEN - 1; i >= 0; i--) if (v[i]) n = 6'(i);
    return n;
  endfunction

  function automatic logic [5:0] f_cpop(input logic [XLEN-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, bmu_sel;
  logic       unused_rs1_field;

  assign opcode           = instr_i[6:0];
  assign rd               = instr_i[11:7];
  assign funct3           = instr_i[14:12];
  assign bmu_sel          = instr_i[24:20];
  assign funct7           = instr_i[31:25];
  assign unused_rs1_field = ^instr_i[19:15];

  logic [XLEN-1:0] rd_data_d, redirect_pc_d;
  logic            wr_d, is_br, br_cond, is_jmp, taken;

  always_comb begin
    rd_data_d     = '0;
    wr_d          = 1'b0;
    is_br         = 1'b0;
    br_cond       = 1'b0;
    is_jmp        = 1'b0;
    redirect_pc_d = pc_i + imm_i;
    case (opcode)
      OPC_LUI:   begin wr_d = 1'b1; rd_data_d = imm_i; end
      OPC_AUIPC: begin wr_d = 1'b1; rd_data_d = pc_i + imm_i; end
      OPC_JAL:   begin wr_d = 1'b1; is_jmp = 1'b1; rd_data_d = pc_i + 32'd4; end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          wr_d          = 1'b1;
          is_jmp        = 1'b1;
          rd_data_d     = pc_i + 32'd4;
          redirect_pc_d = (rs1_i + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        is_br = 1'b1;
        case (funct3)
          3'b000:  br_cond = (rs1_i == rs2_i);
          3'b001:  br_cond = (rs1_i != rs2_i);
          3'b100:  br_cond = ($signed(rs1_i) <  $signed(rs2_i));
          3'b101:  br_cond = ($signed(rs1_i) >= $signed(rs2_i));
          3'b110:  br_cond = (rs1_i <  rs2_i);
          3'b111:  br_cond = (rs1_i >= rs2_i);
          default: is_br   = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        wr_d = 1'b1;
        case (funct3)
          3'b000: rd_data_d = rs1_i + imm_i;
          3'b010: rd_data_d = {31'd0, ($signed(rs1_i) < $signed(imm_i))};
          3'b011: rd_data_d = {31'd0, (rs1_i < imm_i)};
          3'b100: rd_data_d = rs1_i ^ imm_i;
          3'b110: rd_data_d = rs1_i | imm_i;
          3'b111: rd_data_d = rs1_i & imm_i;
          3'b001: begin
            if (funct7 == F7_BASE)                       rd_data_d = rs1_i << shamt_i;
            else if (funct7 == F7_BMU && bmu_sel == 5'd0) rd_data_d = {26'd0, f_clz(rs1_i)};
            else if (funct7 == F7_BMU && bmu_sel == 5'd1) rd_data_d = {26'd0, f_ctz(rs1_i)};
            else if (funct7 == F7_BMU && bmu_sel == 5'd2) rd_data_d = {26'd0, f_cpop(rs1_i)};
            else                                          wr_d      = 1'b0;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     rd_data_d = rs1_i >> shamt_i;
            else if (funct7 == F7_ALT) rd_data_d = $signed(rs1_i) >>> shamt_i;
            else                       wr_d      = 1'b0;
          end
          default: wr_d = 1'b0;
        endcase
      end
      OPC_OP: begin
        wr_d = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: rd_data_d = rs1_i + rs2_i;
          {F7_ALT,  3'b000}: rd_data_d = rs1_i - rs2_i;
          {F7_BASE, 3'b001}: rd_data_d = rs1_i << rs2_i[4:0];
          {F7_BASE, 3'b010}: rd_data_d = {31'd0, ($signed(rs1_i) < $signed(rs2_i))};
          {F7_BASE, 3'b011}: rd_data_d = {31'd0, (rs1_i < rs2_i)};
          {F7_BASE, 3'b100}: rd_data_d = rs1_i ^ rs2_i;
          {F7_BASE, 3'b101}: rd_data_d = rs1_i >> rs2_i[4:0];
          {F7_ALT,  3'b101}: rd_data_d = $signed(rs1_i) >>> rs2_i[4:0];
          {F7_BASE, 3'b110}: rd_data_d = rs1_i | rs2_i;
          {F7_BASE, 3'b111}: rd_data_d = rs1_i & rs2_i;
          default:           wr_d      = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign taken = is_jmp | (is_br & br_cond);

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic [XLEN-1:0] rd_data_q, redirect_pc_q, instr_q;
  logic [4:0]      rd_addr_q;
  logic            rd_we_q, redirect_valid_q, flush_q, prio_q;

  // The shadow counter holds the number of slots still to kill, including the current one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= S_RUN;
      cnt_q            <= '0;
      rd_data_q        <= '0;
      rd_addr_q        <= '0;
      rd_we_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      instr_q          <= '0;
      prio_q           <= 1'b0;
    end else begin
      prio_q           <= prio_i;
      rd_data_q        <= rd_data_d;
      rd_addr_q        <= rd;
      redirect_valid_q <= 1'b0;
      if (state_q == S_RUN) begin
        rd_we_q <= wr_d && (rd != 5'd0);
        instr_q <= instr_i;
        if (taken) begin
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= redirect_pc_d;
          flush_q          <= 1'b1;
          cnt_q            <= 3'(FLUSH_CYCLES);
          state_q          <= S_FLUSH;
        end
      end else begin
        rd_we_q <= 1'b0;
        instr_q <= '0;
        if (cnt_q == 3'd1) begin
          flush_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_RUN;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
    end
  end

  assign rd_data_o        = rd_data_q;
  assign rd_addr_o        = rd_addr_q;
  assign rd_we_o          = rd_we_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign instr_o          = instr_q;
  assign prio_o           = prio_q;

`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0] stat_taken_q, stat_nottaken_q, stat_killed_q;
  logic            kill_ev;

  assign kill_ev = (state_q == S_FLUSH) && (instr_i != 32'h0) && (instr_i != 32'h13);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_taken_q    <= '0;
      stat_nottaken_q <= '0;
      stat_killed_q   <= '0;
    end else begin
      if (state_q == S_RUN && taken && !(&stat_taken_q))
        stat_taken_q <= stat_taken_q + 32'd1;
      if (state_q == S_RUN && is_br && !br_cond && !(&stat_nottaken_q))
        stat_nottaken_q <= stat_nottaken_q + 32'd1;
      if (kill_ev && !(&stat_killed_q))
        stat_killed_q <= stat_killed_q + 32'd1;
    end
  end

  assign stat_taken_o    = stat_taken_q;
  assign stat_nottaken_o = stat_nottaken_q;
  assign stat_killed_o   = stat_killed_q;
`endif

endmodule

// File: tb/tb_execute_branch.sv
// tb_execute_branch: directed test-plan cases plus random instruction stream vs. a behavioural model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_execute_branch;
  localparam int FC = 2;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] instr_i, pc_i, rs1_i, rs2_i, imm_i;
  logic [4:0]  shamt_i;
  logic        prio_i;
  logic [31:0] rd_data_o, redirect_pc_o, instr_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o, redirect_valid_o, flush_o, prio_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken_o, stat_nottaken_o, stat_killed_o;
`endif

  always #5 clk_i = ~clk_i;

  execute_branch #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .instr_i(instr_i), .pc_i(pc_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .shamt_i(shamt_i), .imm_i(imm_i), .prio_i(prio_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .instr_o(instr_o),
`ifdef BRANCH_STATS_EN
    .stat_taken_o(stat_taken_o), .stat_nottaken_o(stat_nottaken_o), .stat_killed_o(stat_killed_o),
`endif
    .prio_o(prio_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: slots left to kill and the last redirect target.
  int          m_shadow;
  logic [31:0] m_rpc;
`ifdef BRANCH_STATS_EN
  logic [31:0] m_taken, m_nottaken, m_killed;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2f, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] sra_ref(input logic [31:0] x, input int s);
    logic [31:0] r;
    r = x >> s;
    if (x[31]) r = r | ~(32'hFFFF_FFFF >> s);
    return r;
  endfunction

  function automatic logic [31:0] clz_ref(input logic [31:0] x);
    int n = 0;
    for (int k = 31; k >= 0; k--) begin
      if (x[k]) break;
      n++;
    end
    return 32'(n);
  endfunction

  function automatic logic [31:0] ctz_ref(input logic [31:0] x);
    int n = 0;
    for (int k = 0; k < 32; k++) begin
      if (x[k]) break;
      n++;
    end
    return 32'(n);
  endfunction

  task automatic ref_exec(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] im,
                          output bit wr, output logic [31:0] val, output bit xfer,
                          output logic [31:0] tgt, output bit br_nt);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] sel;
    int         sa, sb, si;
    bit         is_b, cond;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; sel = ins[24:20];
    sa = a; sb = b; si = im;
    wr = 0; val = 0; xfer = 0; tgt = pc + im; br_nt = 0; is_b = 0; cond = 0;
    case (op)
      7'h37: begin wr = 1; val = im; end
      7'h17: begin wr = 1; val = pc + im; end
      7'h6F: begin wr = 1; val = pc + 4; xfer = 1; end
      7'h67: if (f3 == 3'd0) begin wr = 1; val = pc + 4; xfer = 1; tgt = (a + im) & 32'hFFFF_FFFE; end
      7'h63: begin
        is_b = 1;
        case (f3)
          3'd0: cond = (a == b);
          3'd1: cond = (a != b);
          3'd4: cond = (sa < sb);
          3'd5: cond = (sa >= sb);
          3'd6: cond = (a < b);
          3'd7: cond = (a >= b);
          default: is_b = 0;
        endcase
        xfer  = is_b && cond;
        br_nt = is_b && !cond;
      end
      7'h13: begin
        wr = 1;
        case (f3)
          3'd0: val = a + im;
          3'd2: val = (sa < si) ? 1 : 0;
          3'd3: val = (a < im) ? 1 : 0;
          3'd4: val = a ^ im;
          3'd6: val = a | im;
          3'd7: val = a & im;
          3'd1: begin
            if (f7 == 7'h00) val = a << sh;
            else if (f7 == 7'h30 && sel == 0) val = clz_ref(a);
            else if (f7 == 7'h30 && sel == 1) val = ctz_ref(a);
            else if (f7 == 7'h30 && sel == 2) val = $countones(a);
            else wr = 0;
          end
          default: begin
            if (f7 == 7'h00) val = a >> sh;
            else if (f7 == 7'h20) val = sra_ref(a, int'(sh));
            else wr = 0;
          end
        endcase
      end
      7'h33: begin
        wr = 1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: val = a + b;
            3'd1: val = a << b[4:0];
            3'd2: val = (sa < sb) ? 1 : 0;
            3'd3: val = (a < b) ? 1 : 0;
            3'd4: val = a ^ b;
            3'd5: val = a >> b[4:0];
            3'd6: val = a | b;
            default: val = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) val = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) val = sra_ref(a, int'(b[4:0]));
        else wr = 0;
      end
      default: ;
    endcase
    if (ins[11:7] == 5'd0) wr = 0;
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic [31:0] im,
                      input logic pr);
    bit          wr, xfer, br_nt, e_we, e_rv, e_fl;
    logic [31:0] val, tgt, e_ins;
    instr_i = ins; pc_i = pc; rs1_i = a; rs2_i = b; shamt_i = sh; imm_i = im; prio_i = pr;
    ref_exec(ins, pc, a, b, sh, im, wr, val, xfer, tgt, br_nt);
    if (m_shadow > 0) begin
      e_we = 0; e_rv = 0; e_ins = 0; e_fl = (m_shadow > 1);
      m_shadow--;
`ifdef BRANCH_STATS_EN
      if (ins != 32'h0 && ins != 32'h13) m_killed = sat_inc(m_killed);
`endif
    end else begin
      e_we = wr; e_rv = xfer; e_fl = xfer; e_ins = ins;
      if (xfer) begin
        m_rpc    = tgt;
        m_shadow = FC;
      end
`ifdef BRANCH_STATS_EN
      if (xfer)  m_taken    = sat_inc(m_taken);
      if (br_nt) m_nottaken = sat_inc(m_nottaken);
`endif
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check_val("rd_we", 32'(rd_we_o), 32'(e_we));
    if (e_we) begin
      check_val("rd_data", rd_data_o, val);
      check_val("rd_addr", 32'(rd_addr_o), 32'(ins[11:7]));
    end
    check_val("redirect_valid", 32'(redirect_valid_o), 32'(e_rv));
    check_val("redirect_pc", redirect_pc_o, m_rpc);
    check_val("flush", 32'(flush_o), 32'(e_fl));
    check_val("instr_o", instr_o, e_ins);
    check_val("prio", 32'(prio_o), 32'(pr));
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_rd_data"}, rd_data_o, 32'd0);
    check_val({pfx, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    check_val({pfx, "_rd_we"}, 32'(rd_we_o), 32'd0);
    check_val({pfx, "_rv"}, 32'(redirect_valid_o), 32'd0);
    check_val({pfx, "_rpc"}, redirect_pc_o, 32'd0);
    check_val({pfx, "_flush"}, 32'(flush_o), 32'd0);
    check_val({pfx, "_instr"}, instr_o, 32'd0);
    check_val({pfx, "_prio"}, 32'(prio_o), 32'd0);
`ifdef BRANCH_STATS_EN
    check_val({pfx, "_st_taken"}, stat_taken_o, 32'd0);
    check_val({pfx, "_st_nt"}, stat_nottaken_o, 32'd0);
    check_val({pfx, "_st_killed"}, stat_killed_o, 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_shadow = 0;
    m_rpc    = 32'd0;
`ifdef BRANCH_STATS_EN
    m_taken = 0; m_nottaken = 0; m_killed = 0;
`endif
  endtask

  task automatic gen_rand(output logic [31:0] ins, output logic [31:0] pc, output logic [31:0] a,
                          output logic [31:0] b, output logic [4:0] sh, output logic [31:0] im);
    logic [6:0] f7, op;
    logic [4:0] rs2f, rd;
    logic [2:0] f3;
    int         kind, pick;
    kind = $urandom_range(0, 11);
    pick = $urandom_range(0, 3);
    f3   = 3'($urandom_range(0, 7));
    rd   = 5'($urandom_range(0, 31));
    rs2f = 5'($urandom_range(0, 31));
    f7   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
    a    = $urandom;
    b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'd0;
    sh   = 5'($urandom);
    im   = $urandom;
    pc   = $urandom & 32'hFFFF_FFFC;
    case (kind)
      0: op = 7'h37;
      1: op = 7'h17;
      2: op = 7'h6F;
      3: begin op = 7'h67; if ($urandom_range(0, 3) != 0) f3 = 3'd0; end
      4, 5: op = 7'h63;
      6, 7: begin
        op = 7'h13;
        if (pick == 0) f7 = 7'h00;
        else if (pick == 1) f7 = 7'h20;
        else if (pick == 2) begin f7 = 7'h30; rs2f = 5'($urandom_range(0, 3)); end
      end
      8, 9: begin op = 7'h33; if (pick < 2) f7 = 7'h20; end
      default: op = 7'h00;
    endcase
    ins = {f7, rs2f, 5'($urandom), f3, rd, op};
    if (kind == 10) ins = ($urandom_range(0, 1) == 1) ? 32'h13 : 32'h0;
    if (kind == 11) ins = $urandom;
  endtask

  initial begin
    logic [31:0] r_ins, r_pc, r_a, r_b, r_im;
    logic [4:0]  r_sh;
    rstn_i = 1'b0; instr_i = '0; pc_i = '0; rs1_i = '0; rs2_i = '0;
    shamt_i = '0; imm_i = '0; prio_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rstn_i = 1'b1;

    step(enc(7'h00, 5'd2, 3'b000, 5'd5, 7'h33), 32'h40, 32'd7, 32'hFFFF_FFFC, 5'd0, 32'd0, 1'b1);
    check_val("add_data", rd_data_o, 32'd3);
    check_val("add_addr", 32'(rd_addr_o), 32'd5);

    step(enc(7'h00, 5'd2, 3'b000, 5'd0, 7'h63), 32'h100, 32'd5, 32'd5, 5'd0, 32'h20, 1'b0);
    check_val("beq_rpc", redirect_pc_o, 32'h120);
    check_val("beq_rv", 32'(redirect_valid_o), 32'd1);
    step(enc(7'h00, 5'd9, 3'b000, 5'd3, 7'h13), 32'h104, 32'd0, 32'd0, 5'd0, 32'd9, 1'b1);
    check_val("shadow1_flush", 32'(flush_o), 32'd1);
    step(enc(7'h00, 5'd9, 3'b000, 5'd3, 7'h13), 32'h108, 32'd0, 32'd0, 5'd0, 32'd9, 1'b0);
    check_val("shadow2_flush", 32'(flush_o), 32'd0);
    check_val("shadow2_instr", instr_o, 32'd0);

    step(enc(7'h00, 5'd2, 3'b110, 5'd0, 7'h63), 32'h300, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h40, 1'b0);
    step(enc(7'h00, 5'd9, 3'b000, 5'd3, 7'h13), 32'h304, 32'd0, 32'd0, 5'd0, 32'd9, 1'b0);
    check_val("bltu_next_addi", rd_data_o, 32'd9);

    step(enc(7'h00, 5'd0, 3'b000, 5'd1, 7'h67), 32'h200, 32'h1001, 32'd0, 5'd0, 32'd2, 1'b1);
    check_val("jalr_link", rd_data_o, 32'h204);
    check_val("jalr_tgt", redirect_pc_o, 32'h1002);
    step(enc(7'h00, 5'd0, 3'b000, 5'd1, 7'h6F), 32'h204, 32'd0, 32'd0, 5'd0, 32'h80, 1'b0);
    check_val("shadow_jal_rv", 32'(redirect_valid_o), 32'd0);
    step(32'h13, 32'h208, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);

    step(enc(7'h30, 5'd0, 3'b001, 5'd4, 7'h13), 32'h400, 32'h0001_0000, 32'd0, 5'd0, 32'd0, 1'b0);
    check_val("clz", rd_data_o, 32'd15);
    step(enc(7'h30, 5'd1, 3'b001, 5'd4, 7'h13), 32'h404, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    check_val("ctz_zero", rd_data_o, 32'd32);
    step(enc(7'h30, 5'd2, 3'b001, 5'd4, 7'h13), 32'h408, 32'hF0F0_F0F0, 32'd0, 5'd0, 32'd0, 1'b0);
    check_val("cpop", rd_data_o, 32'd16);
    step(enc(7'h20, 5'd4, 3'b101, 5'd6, 7'h13), 32'h40C, 32'h8000_0000, 32'd0, 5'd4, 32'd0, 1'b1);
    check_val("srai", rd_data_o, 32'hF800_0000);
    step(enc(7'h00, 5'd2, 3'b000, 5'd0, 7'h33), 32'h410, 32'd1, 32'd2, 5'd0, 32'd0, 1'b0);
    check_val("x0_we", 32'(rd_we_o), 32'd0);

    for (int k = 0; k < 400; k++) begin
      gen_rand(r_ins, r_pc, r_a, r_b, r_sh, r_im);
      step(r_ins, r_pc, r_a, r_b, r_sh, r_im, 1'($urandom));
    end
`ifdef BRANCH_STATS_EN
    check_val("stat_taken", stat_taken_o, m_taken);
    check_val("stat_nottaken", stat_nottaken_o, m_nottaken);
    check_val("stat_killed", stat_killed_o, m_killed);
`endif

    step(enc(7'h00, 5'd2, 3'b000, 5'd0, 7'h63), 32'h500, 32'd8, 32'd8, 5'd0, 32'h10, 1'b1);
    check_val("pre_rst_flush", 32'(flush_o), 32'd1);
    #1 rstn_i = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    model_reset();
    step(enc(7'h00, 5'd2, 3'b000, 5'd5, 7'h33), 32'h600, 32'd10, 32'd20, 5'd0, 32'd0, 1'b0);
    check_val("post_rst_we", 32'(rd_we_o), 32'd1);
    check_val("post_rst_data", rd_data_o, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/execute_branch.md
Name: execute_branch

Overview:
- Execute stage of the branch/ALU issue pipe. Sits directly downstream of the branch-pipe decode stage.
- Consumes the registered decode outputs: operands, shift amount, immediate, pc, instruction and priority bit.
- Computes the ALU result and resolves branches and jumps.
- Registers the write-back data and the pc redirect, and drives a multi-cycle flush to the front end on any taken control transfer.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a taken branch or jump (legal range 1..7).
- XLEN, 32, datapath width (only 32 is supported).

Ports:
- clk_i  in  1  clock, all state on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- instr_i  in  32  instruction from decode; 0x00000000 and 0x00000013 are NOPs.
- pc_i  in  32  pc of instr_i.
- rs1_i  in  32  source operand 1.
- rs2_i  in  32  source operand 2.
- shamt_i  in  5  immediate shift amount.
- imm_i  in  32  sign-extended immediate, already formatted per opcode by decode.
- prio_i  in  1  issue priority bit from decode.
- rd_data_o  out  32  write-back data.
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  write enable; never asserted for rd = 0.
- redirect_valid_o  out  1  one-cycle pulse when a redirect is issued.
- redirect_pc_o  out  32  redirect target.
- flush_o  out  1  kill signal to issue and decode.
- instr_o  out  32  instruction passed to write-back (NOP when killed).
- prio_o  out  1  registered prio_i.

Behaviour:
- Reset (async, rstn_i = 0): all outputs 0, instr_o = 0, FSM in RUN, flush counter 0. Applies immediately, including mid-flush.
- Latency: one cycle. Everything presented in cycle N appears on the outputs after edge N+1. There is no stall input; decode inserts NOPs itself.
- Supported operations:
  - LUI: rd = imm.
  - AUIPC: rd = pc + imm.
  - JAL: rd = pc + 4; target = pc + imm.
  - JALR (funct3 000): rd = pc + 4; target = (rs1 + imm) & ~1.
  - BRANCH: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned); target = pc + imm; no rd write.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - Shifts: SLLI, SRLI, SRAI (funct7 bit 30 selects arithmetic), shift amount = shamt_i.
  - funct7 0110000 with funct3 001, selected by instr[24:20]: 00000 = CLZ, 00001 = CTZ, 00010 = CPOP. CLZ and CTZ of 0 return 32.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Register shifts use rs2[4:0].
- Unknown opcode or funct: treated as a NOP. rd_we_o = 0, no redirect, instr_o = instr_i.
- Arithmetic: all sums modulo 2^32; wrap-around is silent.
- FSM states:
  - RUN: a taken branch, JAL or JALR registers redirect_valid_o = 1 and redirect_pc_o = target, sets flush_o = 1, loads the counter with FLUSH_CYCLES, and moves to FLUSH. The jump's own rd write completes normally.
  - FLUSH: every incoming instruction is killed: rd_we_o = 0, redirect_valid_o = 0, instr_o = 0. The counter decrements each cycle. When it reaches 1, the next edge clears flush_o and returns to RUN.
- redirect_valid_o is high for exactly one cycle per taken transfer.
- A branch arriving in FLUSH is ignored, even if its condition is taken.
- A not-taken branch causes no flush and no redirect.
- Back-to-back taken branches: the second one is in the shadow and is killed.
- redirect_pc_o holds its last value when redirect_valid_o = 0.
- prio_o follows prio_i every cycle, including killed slots.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds three output ports, all reset to 0:
  - stat_taken_o (32): taken transfers, including jumps.
  - stat_nottaken_o (32): resolved not-taken branches.
  - stat_killed_o (32): instructions killed in FLUSH, NOPs excluded.
- All three counters saturate at 0xFFFFFFFF.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset and ADD: release reset, then ADD x5,x1,x2 with rs1 = 7, rs2 = 0xFFFFFFFC -> next cycle rd_data_o = 3, rd_addr_o = 5, rd_we_o = 1, redirect_valid_o = 0.
- Taken BEQ: pc = 0x100, imm = 0x20, rs1 = rs2 = 5 -> redirect_valid_o = 1 for one cycle with redirect_pc_o = 0x120. flush_o high for exactly 2 cycles. An ADDI x3 in the next two slots gives rd_we_o = 0 and instr_o = 0.
- Not-taken BLTU: rs1 = 0xFFFFFFFF, rs2 = 1 -> no redirect, flush_o = 0, the following ADDI x3,x0,9 writes 9.
- JALR: pc = 0x200, rs1 = 0x1001, imm = 2, rd = 1 -> rd_data_o = 0x204, redirect_pc_o = 0x1002. A JAL in the shadow slot produces no second redirect.
- Bitmanip and shifts:
  - CLZ of 0x00010000 gives 15.
  - CTZ of 0 gives 32.
  - CPOP of 0xF0F0F0F0 gives 16.
  - SRAI of 0x80000000 by 4 gives 0xF8000000.
  - Any write to x0 leaves rd_we_o = 0.
- Async reset mid-flush: drop rstn_i one cycle after a taken branch -> flush_o = 0 and all outputs 0 immediately, without waiting for a clock edge. After release, the FSM is in RUN. With BRANCH_STATS_EN defined, all counters read 0.
